fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, 8, PC and instruction-memory address width.
REQ-002 Parameter DEPTH, 2, prefetch queue entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 CLB  in  1  asynchronous active-low reset; clears all state immediately.
REQ-005 mem_req  out  1  instruction-memory read request.
REQ-006 mem_addr  out  ADDR_W  fetch address; stable while mem_req high.
REQ-007 mem_ack  in  1  memory accepts request; mem_rdata valid same cycle.
REQ-008 mem_rdata  in  8  fetched instruction byte.
REQ-009 instr_valid  out  1  queue head holds a valid instruction.
REQ-010 instr_ready  in  1  control FSM consumes head this cycle.
REQ-011 instr_out  out  8  queue head instruction.
REQ-012 opcode  out  4  instr_out[7:4].
REQ-013 imm  out  4  instr_out[3:0].
REQ-014 instr_pc  out  ADDR_W  address of queue head instruction.
REQ-015 load_pc  in  1  redirect request; flushes fetch stream.
REQ-016 sel_pc  in  1  target select: 1 = reg_in, 0 = {exec_pc[7:4], imm_in}.
REQ-017 reg_in  in  ADDR_W  register-sourced jump target.
REQ-018 imm_in  in  4  immediate jump offset within current 16-byte page.

Function
REQ-019 Queue push on mem_req && mem_ack (if not discarding); pop on instr_valid && instr_ready; simultaneous push and pop keeps count unchanged.
REQ-020 instr_valid = (count != 0); instr_out/instr_pc show head combinationally from queue storage.
REQ-021 exec_pc register loads instr_pc on every pop; reset 0x00.
REQ-022 fetch_pc increments by 1 on each accepted non-discarded fetch, mod 2^ADDR_W (0xFF -> 0x00).
REQ-023 FSM states: IDLE, WAIT, DISCARD.
REQ-024 IDLE: if count + (pop this cycle ? -1 : 0) < DEPTH, assert mem_req next cycle with mem_addr = fetch_pc and go WAIT; else stay IDLE with mem_req low.
REQ-025 WAIT: hold mem_req and mem_addr until mem_ack; on mem_ack push mem_rdata with pc = mem_addr, then issue back-to-back if space remains after this cycle's push/pop, else IDLE.
REQ-026 At most one request outstanding; a new request never issues when queue would be full after the pending push.
REQ-027 load_pc (any state): queue cleared (count = 0, instr_valid low next cycle), fetch_pc = target, pop ignored that cycle.
REQ-028 load_pc in WAIT without mem_ack same cycle: go DISCARD; mem_req and mem_addr held until mem_ack; returned data dropped; then issue at fetch_pc.
REQ-029 load_pc in WAIT with mem_ack same cycle: data dropped, next request issues at target next cycle.
REQ-030 load_pc in DISCARD: update fetch_pc only, remain DISCARD.
REQ-031 Redirect-to-first-request latency: 1 cycle from load_pc when no request in flight.
REQ-032 Target for sel_pc = 0 uses exec_pc before any same-cycle update.

Reset
REQ-033 CLB low: state IDLE, mem_req 0, mem_addr 0x00, fetch_pc 0x00, exec_pc 0x00, count 0, instr_valid 0, instr_out 0x00, instr_pc 0x00.
REQ-034 CLB asserted mid-request abandons it; after release first request is address 0x00, first cycle after release has mem_req low.
REQ-035 Reset deassertion is synchronised externally; block needs no internal reset synchroniser.

Verification
REQ-036 Reset release, mem_ack tied high, instr_ready low -> requests 0x00, 0x01, then mem_req low; instr_valid high with instr_out = mem[0x00].
REQ-037 mem_ack delayed 3 cycles, instr_ready high -> mem_addr stable during wait; instr_pc sequence 0x00, 0x01, 0x02 in order, no duplicates or gaps.
REQ-038 fetch_pc at 0xFE, continuous ack/ready -> instr_pc 0xFE, 0xFF, 0x00.
REQ-039 load_pc=1, sel_pc=1, reg_in=0x40 while WAIT, ack 2 cycles later -> in-flight byte dropped, instr_valid low until instr_pc = 0x40 appears.
REQ-040 exec_pc=0x37, load_pc=1, sel_pc=0, imm_in=0x9, same-cycle pop -> queue flushed, next fetch address 0x39.
REQ-041 CLB pulsed low during WAIT -> all outputs at reset values immediately; first post-reset fetch at 0x00.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Groups the buses of the instruction fetch unit: the instruction-memory
// read port, the decoded queue-head port toward the control FSM, and the
// redirect (jump) port.
//
// Signals:
//   mem_req / mem_addr        fetch unit -> memory: read request + address
//   mem_ack / mem_rdata       memory -> fetch unit: accept + same-cycle byte
//   instr_valid / instr_out   fetch unit -> control: queue head + valid
//   opcode / imm / instr_pc   fetch unit -> control: head fields + address
//   instr_ready               control -> fetch unit: head consumed this cycle
//   load_pc / sel_pc          control -> fetch unit: redirect + target select
//   reg_in / imm_in           control -> fetch unit: jump target sources
//
// Modports: master = the fetch unit, slave = its environment.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_out;
    logic [3:0]        opcode;
    logic [3:0]        imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              load_pc;
    logic              sel_pc;
    logic [ADDR_W-1:0] reg_in;
    logic [3:0]        imm_in;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_out, opcode, imm, instr_pc,
        input  mem_ack, mem_rdata, instr_ready, load_pc, sel_pc, reg_in, imm_in
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_out, opcode, imm, instr_pc,
        output mem_ack, mem_rdata, instr_ready, load_pc, sel_pc, reg_in, imm_in
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction prefetcher: issues one byte read at a time to instruction
// memory, keeps up to DEPTH fetched bytes (with their addresses) in a small
// queue, and presents the queue head to the control FSM. A redirect
// (load_pc) flushes the queue and restarts fetching at the jump target; a
// read already in flight at that moment is completed and its data dropped.
//
// Ports:
//   clk  - single clock, rising edge
//   CLB  - asynchronous active-low reset
//   bus  - fetch_unit_if.master (memory, queue-head and redirect buses)
//
// Parameters:
//   ADDR_W - PC / memory address width (>= 5, the page is the upper bits)
//   DEPTH  - prefetch queue entries, power of two, >= 2
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          CLB,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [7:0]        q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] head_pc;
    // Only the page bits of the executing pc ever feed a redirect target,
    // so only those bits are kept.
    logic [ADDR_W-5:0] exec_page;

    logic              push;
    logic              pop;
    logic              space;
    logic              issue;

    // Queue head is shown straight out of storage.
    assign head_pc         = q_pc[rd_ptr];
    assign bus.instr_pc    = head_pc;
    assign bus.instr_out   = q_data[rd_ptr];
    assign bus.opcode      = q_data[rd_ptr][7:4];
    assign bus.imm         = q_data[rd_ptr][3:0];
    assign bus.instr_valid = (count != '0);
    assign bus.mem_req     = (state != IDLE);
    assign bus.mem_addr    = mem_addr_q;

    // A redirect wins over everything: the returning byte (if any) is not
    // queued and a head consumption in that cycle is ignored. A byte that
    // arrives while DISCARD is active belongs to the abandoned stream.
    assign push   = (state == WAIT) && bus.mem_ack && !bus.load_pc;
    assign pop    = bus.instr_valid && bus.instr_ready && !bus.load_pc;
    assign target = bus.sel_pc ? bus.reg_in : {exec_page, bus.imm_in};

    // Occupancy after this cycle; a new read may only go out if the byte it
    // returns is guaranteed a free slot.
    always_comb begin
        count_next = count;
        if (bus.load_pc) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign space = (count_next < CNT_W'(DEPTH));

    // Next fetch address: redirect target, else advance past an accepted byte.
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (bus.load_pc) begin
            fetch_pc_next = target;
        end else if (push) begin
            fetch_pc_next = fetch_pc + ADDR_W'(1);
        end
    end

    // Fetch sequencing. 'issue' means a fresh request starts next cycle at
    // fetch_pc_next; WAIT itself keeps mem_req/mem_addr frozen until ack.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (space) begin
                    state_next = WAIT;
                    issue      = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    if (space) begin
                        issue = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.load_pc) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) begin
                    if (space) begin
                        state_next = WAIT;
                        issue      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, fetch pointer, request address and executing page.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            mem_addr_q <= '0;
            exec_page  <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (issue) begin
                mem_addr_q <= fetch_pc_next;
            end
            if (pop) begin
                exec_page <= head_pc[ADDR_W-1:4];
            end
        end
    end

    // Prefetch queue storage and pointers; a redirect empties it.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (bus.load_pc) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= bus.mem_rdata;
                    q_pc[wr_ptr]   <= mem_addr_q;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural memory answers requests with
// a configurable ack delay; every instruction the bench expects to see
// consumed is pushed to a scoreboard queue and compared when the DUT hands
// it over (instr_valid && instr_ready).
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic CLB;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(2)) dut (
        .clk (clk),
        .CLB (CLB),
        .bus (bus)
    );

    int                checks   = 0;
    int                failures = 0;
    logic [ADDR_W-1:0] sb_q[$];
    int                req_age  = 0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [ADDR_W-1:0] old_addr;

    // Memory contents: nibble swap scrambled with a constant.
    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return {a[3:0], a[7:4]} ^ 8'hC3;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of memory responder + consumer, then advance past the edge.
    task automatic apply_stimulus(input int ack_delay, input logic ready);
        logic [ADDR_W-1:0] exp_pc;
        bus.mem_rdata   = mem_byte(bus.mem_addr);
        bus.instr_ready = ready;
        if (bus.mem_req) begin
            if (req_age == 0) begin
                req_addr = bus.mem_addr;
            end else begin
                check_output("addr_stable", bus.mem_addr, req_addr);
            end
            bus.mem_ack = (req_age >= ack_delay);
            req_age     = bus.mem_ack ? 0 : req_age + 1;
        end else begin
            bus.mem_ack = 1'b0;
            req_age     = 0;
        end
        if (bus.instr_valid && ready && !bus.load_pc) begin
            check_output("pop_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                check_output("instr_pc", bus.instr_pc, exp_pc);
                check_output("instr_out", bus.instr_out, mem_byte(exp_pc));
                check_output("opcode", bus.opcode, mem_byte(exp_pc) >> 4);
                check_output("imm", bus.imm, mem_byte(exp_pc) & 8'h0F);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_drained(input int ack_delay, input int budget);
        int n = 0;
        req_age = 0;
        while (sb_q.size() != 0 && n < budget) begin
            apply_stimulus(ack_delay, 1'b1);
            n++;
        end
        check_output("drain_done", sb_q.size(), 0);
    endtask

    // Ack everything, consume nothing, until the unit stops requesting.
    task automatic fill_queue(input int budget);
        int n = 0;
        req_age = 0;
        while (bus.mem_req && n < budget) begin
            apply_stimulus(0, 1'b0);
            n++;
        end
        check_output("fill_idle", bus.mem_req, 0);
    endtask

    task automatic wait_for_req(input int budget);
        int n = 0;
        while (!bus.mem_req && n < budget) begin
            bus.mem_ack     = 1'b0;
            bus.instr_ready = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check_output("req_seen", bus.mem_req, 1);
    endtask

    task automatic redirect(input logic sel, input logic [ADDR_W-1:0] reg_target,
                            input logic [3:0] imm_target, input logic ready);
        bus.load_pc     = 1'b1;
        bus.sel_pc      = sel;
        bus.reg_in      = reg_target;
        bus.imm_in      = imm_target;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = ready;
        @(posedge clk);
        #1;
        bus.load_pc = 1'b0;
        sb_q.delete();
        check_output("flush_valid", bus.instr_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_mem_req"}, bus.mem_req, 0);
        check_output({tag, "_mem_addr"}, bus.mem_addr, 0);
        check_output({tag, "_valid"}, bus.instr_valid, 0);
        check_output({tag, "_instr_out"}, bus.instr_out, 0);
        check_output({tag, "_instr_pc"}, bus.instr_pc, 0);
    endtask

    initial begin
        CLB             = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.instr_ready = 1'b0;
        bus.load_pc     = 1'b0;
        bus.sel_pc      = 1'b0;
        bus.reg_in      = '0;
        bus.imm_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        $display("[TB] ack tied high, no consumption");
        CLB         = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        check_output("release_no_req", bus.mem_req, 0);
        @(posedge clk);
        #1;
        check_output("req0_req", bus.mem_req, 1);
        check_output("req0_addr", bus.mem_addr, 8'h00);
        bus.mem_rdata = mem_byte(bus.mem_addr);
        @(posedge clk);
        #1;
        check_output("req1_req", bus.mem_req, 1);
        check_output("req1_addr", bus.mem_addr, 8'h01);
        bus.mem_rdata = mem_byte(bus.mem_addr);
        @(posedge clk);
        #1;
        check_output("full_no_req", bus.mem_req, 0);
        check_output("full_valid", bus.instr_valid, 1);
        check_output("full_head", bus.instr_out, mem_byte(8'h00));
        check_output("full_head_pc", bus.instr_pc, 8'h00);
        @(posedge clk);
        #1;
        check_output("full_still_idle", bus.mem_req, 0);

        $display("[TB] slow memory, continuous consumption");
        for (int i = 0; i < 5; i++) sb_q.push_back(ADDR_W'(i));
        run_until_drained(3, 200);

        $display("[TB] wrap across 0xFF");
        redirect(1'b1, 8'hFE, 4'h0, 1'b0);
        sb_q.push_back(8'hFE);
        sb_q.push_back(8'hFF);
        sb_q.push_back(8'h00);
        sb_q.push_back(8'h01);
        run_until_drained(0, 100);

        $display("[TB] redirect while a read is in flight");
        wait_for_req(20);
        old_addr = bus.mem_addr;
        redirect(1'b1, 8'h40, 4'h0, 1'b1);
        check_output("discard_req", bus.mem_req, 1);
        check_output("discard_addr_hold", bus.mem_addr, old_addr);
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("discard_addr_hold2", bus.mem_addr, old_addr);
        check_output("discard_valid", bus.instr_valid, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_byte(bus.mem_addr);
        @(posedge clk);
        #1;
        check_output("dropped_valid", bus.instr_valid, 0);
        check_output("target_req", bus.mem_req, 1);
        check_output("target_addr", bus.mem_addr, 8'h40);
        sb_q.push_back(8'h40);
        sb_q.push_back(8'h41);
        run_until_drained(0, 50);

        $display("[TB] page-relative redirect with same-cycle pop");
        redirect(1'b1, 8'h37, 4'h0, 1'b0);
        fill_queue(50);
        check_output("pre_head_pc", bus.instr_pc, 8'h37);
        sb_q.push_back(8'h37);
        apply_stimulus(0, 1'b1);
        fill_queue(50);
        check_output("pre_jump_head", bus.instr_pc, 8'h38);
        redirect(1'b0, 8'h00, 4'h9, 1'b1);
        check_output("jump_req", bus.mem_req, 1);
        check_output("jump_addr", bus.mem_addr, 8'h39);
        sb_q.push_back(8'h39);
        sb_q.push_back(8'h3A);
        run_until_drained(0, 50);

        $display("[TB] reset during an outstanding read");
        wait_for_req(20);
        bus.mem_ack = 1'b0;
        #2;
        CLB = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        CLB = 1'b1;
        #1;
        check_output("rerelease_no_req", bus.mem_req, 0);
        @(posedge clk);
        #1;
        check_output("rerelease_req", bus.mem_req, 1);
        check_output("rerelease_addr", bus.mem_addr, 8'h00);
        sb_q.delete();
        for (int i = 0; i < 3; i++) sb_q.push_back(ADDR_W'(i));
        run_until_drained(1, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
